// File: rtl/soc_serial_pkg.sv
// rtl/soc_serial_pkg.sv - shared state encoding and default pattern for serial detector/transmitter
package soc_serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_GAP   = 3'd2,
    ST_DONE  = 3'd3
  } state_t;

  localparam int          STATE_W         = 3;
  localparam logic [4:0]  DEFAULT_PATTERN = 5'b10010;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// rtl/serial_pattern_tx_if.sv - start/busy request and serial output bundle of serial_pattern_tx
interface serial_pattern_tx_if #(
  parameter int PAT_W = 5,
  parameter int REP_W = 4
);

  logic                   start;
  logic [PAT_W-1:0]       pattern;
  logic [REP_W-1:0]       reps;
  logic                   x;
  logic                   x_valid;
  logic                   busy;
  logic                   done;
  soc_serial_pkg::state_t state;

  modport master (
    output start, pattern, reps,
    input  x, x_valid, busy, done, state
  );

  modport slave (
    input  start, pattern, reps,
    output x, x_valid, busy, done, state
  );

endinterface

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, MSB-first shift register
// Shifting fills zeros, so a fully shifted register drives 0 on msb.
module piso_shift_reg #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] q;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= din;
    end else if (shift_en) begin
      q <= {q[W-2:0], 1'b0};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - repeating MSB-first serial pattern transmitter with idle gaps
module serial_pattern_tx
  import soc_serial_pkg::*;
#(
  parameter int PAT_W = 5,
  parameter int REP_W = 4,
  parameter int GAP   = 2
) (
  input  logic               clk,
  input  logic               rst,
  serial_pattern_tx_if.slave bus
);

  localparam int BW = $clog2(PAT_W);
  // A zero-cycle gap still needs a legal one-bit counter; it is never advanced.
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(PAT_W - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  state_t           state_q, state_d;
  logic [PAT_W-1:0] cap_q, cap_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [REP_W-1:0] rep_q, rep_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             sr_load, sr_shift;
  logic [PAT_W-1:0] sr_din;
  logic             sr_msb;

  piso_shift_reg #(.W(PAT_W)) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (sr_load),
    .shift_en (sr_shift),
    .din      (sr_din),
    .msb      (sr_msb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      bit_q   <= bit_d;
      rep_q   <= rep_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cap_d    = cap_q;
    bit_d    = bit_q;
    rep_d    = rep_q;
    gap_d    = gap_q;
    sr_load  = 1'b0;
    sr_shift = 1'b0;
    sr_din   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_SHIFT;
          cap_d   = bus.pattern;
          sr_din  = bus.pattern;
          sr_load = 1'b1;
          bit_d   = '0;
          rep_d   = (bus.reps == '0) ? REP_W'(1) : bus.reps;
        end
      end
      ST_SHIFT: begin
        if (bit_q == BIT_LAST) begin
          rep_d = rep_q - 1'b1;
          bit_d = '0;
          if (rep_q > REP_W'(1)) begin
            if (GAP > 0) begin
              state_d  = ST_GAP;
              gap_d    = '0;
              sr_shift = 1'b1;
            end else begin
              // Back-to-back frames: reload so the next MSB follows with no bubble.
              sr_load = 1'b1;
            end
          end else begin
            state_d  = ST_DONE;
            sr_shift = 1'b1;
          end
        end else begin
          bit_d    = bit_q + 1'b1;
          sr_shift = 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_SHIFT;
          sr_load = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.x       = sr_msb;
  assign bus.x_valid = (state_q == ST_SHIFT);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.done    = (state_q == ST_DONE);
  assign bus.state   = state_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb/tb_serial_pattern_tx.sv - scoreboard bench for serial_pattern_tx (GAP=2 and GAP=0 builds)
module tb_serial_pattern_tx;

  typedef struct packed {
    logic v;
    logic b;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       start_r = 1'b0;
  logic [4:0] pat_r = '0;
  logic [3:0] reps_r = '0;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  serial_pattern_tx_if #(.PAT_W(5), .REP_W(4)) if2 ();
  serial_pattern_tx_if #(.PAT_W(5), .REP_W(4)) if0 ();

  serial_pattern_tx #(.PAT_W(5), .REP_W(4), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
  serial_pattern_tx #(.PAT_W(5), .REP_W(4), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  assign if2.start   = start_r & ~sel;
  assign if0.start   = start_r & sel;
  assign if2.pattern = pat_r;
  assign if0.pattern = pat_r;
  assign if2.reps    = reps_r;
  assign if0.reps    = reps_r;

  logic       s_x, s_xv, s_busy, s_done;
  logic [2:0] s_state;
  assign s_x     = sel ? if0.x       : if2.x;
  assign s_xv    = sel ? if0.x_valid : if2.x_valid;
  assign s_busy  = sel ? if0.busy    : if2.busy;
  assign s_done  = sel ? if0.done    : if2.done;
  assign s_state = sel ? if0.state   : if2.state;

  always #5 clk = ~clk;

  task automatic push_exp(input logic [4:0] pat, input logic [3:0] r, input int gap);
    int nrep;
    nrep = (r == 0) ? 1 : int'(r);
    for (int k = 0; k < nrep; k++) begin
      for (int i = 4; i >= 0; i--) exp_q.push_back('{v: 1'b1, b: pat[i]});
      if (k < nrep - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back('{v: 1'b0, b: 1'b0});
    end
  endtask

  task automatic check_idle(input string name);
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL %s busy got %b exp 0", name, s_busy); end
    checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL %s done got %b exp 0", name, s_done); end
    checks++; if (s_xv !== 1'b0) begin errors++; $display("FAIL %s x_valid got %b exp 0", name, s_xv); end
    checks++; if (s_state !== 3'd0) begin errors++; $display("FAIL %s state got %0d exp 0", name, s_state); end
  endtask

  // Consumes the scoreboard one cycle at a time; returns while sampling the DONE cycle.
  task automatic drain(input string name, input int disturb);
    exp_t e;
    int   n = 0;
    bit   fin = 0;
    for (int c = 0; c < 200 && !fin; c++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n++;
        checks++; if (s_xv !== e.v) begin errors++; $display("FAIL %s x_valid cyc %0d got %b exp %b", name, n, s_xv, e.v); end
        checks++; if (s_x !== e.b) begin errors++; $display("FAIL %s x cyc %0d got %b exp %b", name, n, s_x, e.b); end
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL %s busy cyc %0d got %b exp 1", name, n, s_busy); end
        checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL %s done cyc %0d got %b exp 0", name, n, s_done); end
        checks++; if (s_state !== (e.v ? 3'd1 : 3'd2)) begin errors++; $display("FAIL %s state cyc %0d got %0d exp %0d", name, n, s_state, e.v ? 1 : 2); end
      end else begin
        checks++; if (s_done !== 1'b1) begin errors++; $display("FAIL %s done got %b exp 1", name, s_done); end
        checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL %s done-cycle busy got %b exp 1", name, s_busy); end
        checks++; if (s_state !== 3'd3) begin errors++; $display("FAIL %s done-cycle state got %0d exp 3", name, s_state); end
        fin = 1;
      end
      if (disturb > 0 && n == disturb) begin start_r = 1'b1; pat_r = 5'b00000; reps_r = 4'd5; end
      if (disturb > 0 && n == disturb + 1) start_r = 1'b0;
      if (!fin) @(negedge clk);
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL %s timeout waiting for done", name);
    end
  endtask

  task automatic send(input bit s, input logic [4:0] pat, input logic [3:0] r, input string name, input int disturb);
    sel = s; pat_r = pat; reps_r = r; start_r = 1'b1;
    push_exp(pat, r, s ? 0 : 2);
    @(negedge clk);
    start_r = 1'b0;
    drain(name, disturb);
    @(negedge clk);
    check_idle({name, "_after"});
  endtask

  task automatic test_reset();
    sel = 0; start_r = 1'b1; pat_r = 5'b11111; reps_r = 4'd1; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (s_x !== 1'b0) begin errors++; $display("FAIL reset x got %b exp 0", s_x); end
      check_idle("reset");
    end
    rst = 1'b0; start_r = 1'b0;
    @(negedge clk);
    check_idle("post_reset");
  endtask

  task automatic test_single();
    logic [4:0] p;
    p = soc_serial_pkg::DEFAULT_PATTERN;
    send(0, p, 4'd1, "single", 0);
  endtask

  task automatic test_repeat_gap();
    send(0, 5'b11010, 4'd3, "repeat_gap", 0);
    send(0, 5'b01011, 4'd0, "reps0_gap2", 0);
  endtask

  task automatic test_gap0();
    send(1, 5'b10110, 4'd2, "gap0_x2", 0);
    send(1, 5'b01101, 4'd0, "gap0_reps0", 0);
    send(1, 5'b10001, 4'd3, "gap0_x3", 0);
  endtask

  task automatic test_handshake();
    send(0, 5'b10110, 4'd2, "handshake", 3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_idle("handshake_tail");
    end
  endtask

  task automatic test_done_restart();
    sel = 0; pat_r = 5'b10011; reps_r = 4'd1; start_r = 1'b1;
    push_exp(5'b10011, 4'd1, 2);
    @(negedge clk);
    start_r = 1'b0;
    drain("restart_a", 0);
    start_r = 1'b1; pat_r = 5'b11001;
    @(negedge clk);
    check_idle("restart_idle");
    @(negedge clk);
    start_r = 1'b0;
    push_exp(5'b11001, 4'd1, 2);
    drain("restart_b", 0);
    @(negedge clk);
    check_idle("restart_b_after");
  endtask

  task automatic test_reset_mid();
    logic [4:0] p;
    p = 5'b10110;
    sel = 0; pat_r = p; reps_r = 4'd1; start_r = 1'b1;
    @(negedge clk);
    start_r = 1'b0;
    for (int i = 4; i >= 2; i--) begin
      checks++; if (s_x !== p[i] || s_xv !== 1'b1) begin errors++; $display("FAIL reset_mid bit%0d got %b/%b exp %b/1", i, s_x, s_xv, p[i]); end
      if (i == 2) rst = 1'b1;
      @(negedge clk);
    end
    checks++; if (s_x !== 1'b0) begin errors++; $display("FAIL reset_mid x got %b exp 0", s_x); end
    check_idle("reset_mid");
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_idle("reset_mid_quiet");
    end
    exp_q.delete();
    send(0, p, 4'd1, "reset_fresh", 0);
  endtask

  initial begin
    test_reset();
    test_single();
    test_repeat_gap();
    test_gap0();
    test_handshake();
    test_done_restart();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial bit-pattern transmitter. It is the sending end of the single-bit serial stream (x) consumed by the team's sequence-detector FSMs. It accepts a parallel pattern and a repeat count through a start/busy handshake. It then shifts the pattern out MSB-first, one bit per clock, with a programmable idle gap between repetitions. It replaces random stimulus with deterministic frames for detector bring-up and system-level self-test.

Parameters:
PAT_W, 5, pattern length in bits (>=2)
REP_W, 4, width of repeat-count input
GAP, 2, idle cycles between repetitions (0 allowed = back-to-back frames)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request; sampled only in IDLE
pattern  input  PAT_W  pattern to send, MSB sent first; captured on accepted start
reps  input  REP_W  number of repetitions; captured on accepted start; 0 treated as 1
x  output  1  serial data bit (registered)
x_valid  output  1  high while x carries a pattern bit
busy  output  1  high from cycle after accepted start until DONE completes
done  output  1  one-cycle pulse after final bit
state  output  3  current FSM state (debug)

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, x=0, x_valid=0, busy=0, done=0. Internal shift register, bit counter, rep counter and gap counter are cleared. Reset overrides every other input and takes effect from any state, including mid-frame. No partial frame resumes.
- State encoding: IDLE=3'd0, SHIFT=3'd1, GAP=3'd2, DONE=3'd3. Other codes are unreachable and map to IDLE on the next edge.
- IDLE: outputs 0. When start=1 at an edge:
  - capture pattern into the shift register;
  - capture reps into the rep counter (reps=0 is loaded as 1);
  - go to SHIFT.
- Latency: start is accepted at edge k. In cycle k+1, x=pattern[PAT_W-1] and x_valid=1.
- SHIFT: emit one bit per cycle, MSB first, for exactly PAT_W cycles. busy=1.
  - After the last bit, decrement the rep counter.
  - If repetitions remain and GAP>0: go to GAP.
  - If repetitions remain and GAP=0: reload the shift register from the captured copy and stay in SHIFT. The first bit of the next frame follows with no bubble.
  - If no repetitions remain: go to DONE.
- GAP: x=0, x_valid=0, busy=1 for exactly GAP cycles. Then reload the captured pattern and go to SHIFT.
- DONE: done=1, busy=1, x=0, x_valid=0 for one cycle. Then go to IDLE.
  - start in the DONE cycle is ignored.
  - start in the first IDLE cycle is accepted.
- start while busy: ignored entirely. Changes to pattern and reps while busy have no effect, because the captured copies are used.
- Total busy window for R reps: R*PAT_W + (R-1)*GAP + 1 cycles (the +1 is DONE).
- Counters: the bit counter is ceil(log2(PAT_W)) bits, the gap counter is ceil(log2(GAP+1)) bits, and the rep counter is REP_W bits. No counter may wrap during normal operation.

Decomposition:
- Shared package (soc_serial_pkg): FSM state constants (IDLE/SHIFT/GAP/DONE, 3-bit) and a default detector pattern constant (5'b10010). Detector and transmitter benches import the same values.
- One natural sub-module, piso_shift_reg: a parallel-load, MSB-first shift register with load and shift enables. The FSM and counters stay in the top.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with start=1 -> x=0, x_valid=0, busy=0, done=0, state=0 throughout.
2. Single frame: pattern=5'b10010, reps=1, start for 1 cycle at edge k -> x = 1,0,0,1,0 in cycles k+1..k+5 with x_valid=1; done=1 in cycle k+6; busy low from k+7.
3. Repeat with gap: pattern=5'b11010, reps=3, GAP=2:
   - 5 bits, then 2 cycles with x_valid=0, then 5 bits, 2 gap cycles, 5 bits;
   - done at cycle k+20; busy high for 20 cycles.
4. GAP=0 and reps=0: build with GAP=0; pattern=5'b10110, reps=2 -> 10 consecutive valid bits 1011010110 and done at k+11. Then reps=0 -> exactly one frame.
5. Handshake protection: during an active frame, pulse start and change pattern to 5'b00000 -> the frame continues unchanged and no extra frame follows done.
6. Reset mid-operation: assert rst on the 3rd bit of a frame -> next cycle state=IDLE, x_valid=0, done never pulses. A start after rst deasserts sends a full, fresh frame.
